// File: rtl/npu_circ_buf_param_if.sv
// Bus bundle between an NPU sequencer (master) and the circular buffer (slave).
// Combinational only: no latency.
// No backpressure: the sequencer must watch full/empty/err itself.
interface npu_circ_buf_param_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                npu_circ_buf_clr;
    logic                npu_circ_buf_circ_mode;
    logic                npu_circ_buf_write_en;
    logic                npu_circ_buf_read_en;
    logic [DATA_W-1:0]   npu_circ_buf_data_input;
    logic [DATA_W-1:0]   npu_circ_buf_data_output;
    logic                npu_circ_buf_data_valid;
    logic                npu_circ_buf_pass_done;
    logic [ADDR_W:0]     npu_circ_buf_count;
    logic                npu_circ_buf_full;
    logic                npu_circ_buf_empty;
    logic [2:0]          npu_circ_buf_err;

    modport master (
        output npu_circ_buf_clr,
        output npu_circ_buf_circ_mode,
        output npu_circ_buf_write_en,
        output npu_circ_buf_read_en,
        output npu_circ_buf_data_input,
        input  npu_circ_buf_data_output,
        input  npu_circ_buf_data_valid,
        input  npu_circ_buf_pass_done,
        input  npu_circ_buf_count,
        input  npu_circ_buf_full,
        input  npu_circ_buf_empty,
        input  npu_circ_buf_err
    );

    modport slave (
        input  npu_circ_buf_clr,
        input  npu_circ_buf_circ_mode,
        input  npu_circ_buf_write_en,
        input  npu_circ_buf_read_en,
        input  npu_circ_buf_data_input,
        output npu_circ_buf_data_output,
        output npu_circ_buf_data_valid,
        output npu_circ_buf_pass_done,
        output npu_circ_buf_count,
        output npu_circ_buf_full,
        output npu_circ_buf_empty,
        output npu_circ_buf_err
    );
endinterface

// File: rtl/npu_circ_buf_param.sv
// Parametrised NPU weight/schedule buffer: circular (re-enqueue) or consume FIFO mode.
// Read latency 1 cycle: data_output/data_valid/pass_done registered after the read strobe.
// No backpressure: misuse (overflow, underflow, write+read conflict) is dropped and flagged in sticky err.
module npu_circ_buf_param #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512
) (
    input logic                   CLK,
    input logic                   npu_rst_n,
    npu_circ_buf_param_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    // Reset asserts asynchronously and releases two edges after npu_rst_n rises.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0]  count_q,       count_d;
    logic [ADDR_W-1:0] pass_idx_q,    pass_idx_d;
    logic              circ_mode_q,   circ_mode_d;
    logic [DATA_W-1:0] data_output_q, data_output_d;
    logic              data_valid_q,  data_valid_d;
    logic              pass_done_q,   pass_done_d;
    logic              full_q,        full_d;
    logic              empty_q,       empty_d;
    logic [2:0]        err_q,         err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;
    logic [ADDR_W-1:0] pass_idx_eff;
    logic              mode_chg;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        // Explicit compare so non-power-of-two depths wrap at DEPTH-1.
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    assign rd_word      = mem[rd_ptr_q];
    assign mode_chg     = (bus.npu_circ_buf_circ_mode != circ_mode_q);
    assign pass_idx_eff = mode_chg ? '0 : pass_idx_q;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        pass_idx_d    = pass_idx_eff;
        circ_mode_d   = bus.npu_circ_buf_circ_mode;
        data_output_d = data_output_q;
        data_valid_d  = 1'b0;
        pass_done_d   = 1'b0;
        err_d         = err_q;
        mem_we        = 1'b0;
        mem_waddr     = wr_ptr_q;
        mem_wdata     = bus.npu_circ_buf_data_input;

        if (bus.npu_circ_buf_clr) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            pass_idx_d    = '0;
            circ_mode_d   = 1'b0;
            data_output_d = '0;
            err_d         = '0;
        end else if (bus.npu_circ_buf_write_en) begin
            pass_idx_d = '0;
            if (bus.npu_circ_buf_read_en) begin
                err_d[2] = 1'b1;
            end
            if (full_q) begin
                err_d[0] = 1'b1;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
                count_d  = count_q + CNT_ONE;
            end
        end else if (bus.npu_circ_buf_read_en) begin
            if (empty_q) begin
                err_d[1] = 1'b1;
            end else begin
                data_output_d = rd_word;
                data_valid_d  = 1'b1;
                rd_ptr_d      = ptr_inc(rd_ptr_q);
                if (bus.npu_circ_buf_circ_mode) begin
                    // Word just read goes back to the tail; occupancy is unchanged.
                    mem_we    = 1'b1;
                    mem_wdata = rd_word;
                    wr_ptr_d  = ptr_inc(wr_ptr_q);
                    if ({1'b0, pass_idx_eff} == count_q - CNT_ONE) begin
                        pass_done_d = 1'b1;
                        pass_idx_d  = '0;
                    end else begin
                        pass_idx_d  = pass_idx_eff + PTR_ONE;
                    end
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
        end

        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pass_idx_q    <= '0;
            circ_mode_q   <= 1'b0;
            data_output_q <= '0;
            data_valid_q  <= 1'b0;
            pass_done_q   <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            err_q         <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pass_idx_q    <= pass_idx_d;
            circ_mode_q   <= circ_mode_d;
            data_output_q <= data_output_d;
            data_valid_q  <= data_valid_d;
            pass_done_q   <= pass_done_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            err_q         <= err_d;
        end
    end

    // Storage is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.npu_circ_buf_data_output = data_output_q;
    assign bus.npu_circ_buf_data_valid  = data_valid_q;
    assign bus.npu_circ_buf_pass_done   = pass_done_q;
    assign bus.npu_circ_buf_count       = count_q;
    assign bus.npu_circ_buf_full        = full_q;
    assign bus.npu_circ_buf_empty       = empty_q;
    assign bus.npu_circ_buf_err         = err_q;

endmodule

// File: tb/tb_npu_circ_buf_param.sv
// Directed bench for npu_circ_buf_param: DEPTH=8 and DEPTH=5 instances sharing clock and reset.
module tb_npu_circ_buf_param;
    logic CLK;
    logic npu_rst_n;
    int   total;
    int   bad;

    npu_circ_buf_param_if #(.DATA_W(16), .DEPTH(8)) b8();
    npu_circ_buf_param_if #(.DATA_W(16), .DEPTH(5)) b5();

    npu_circ_buf_param #(.DATA_W(16), .DEPTH(8)) dut8 (
        .CLK       (CLK),
        .npu_rst_n (npu_rst_n),
        .bus       (b8.slave)
    );

    npu_circ_buf_param #(.DATA_W(16), .DEPTH(5)) dut5 (
        .CLK       (CLK),
        .npu_rst_n (npu_rst_n),
        .bus       (b5.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr8(input logic [15:0] d);
        b8.npu_circ_buf_write_en   = 1'b1;
        b8.npu_circ_buf_data_input = d;
        step();
        b8.npu_circ_buf_write_en   = 1'b0;
    endtask

    task automatic clr8();
        b8.npu_circ_buf_clr = 1'b1;
        step();
        b8.npu_circ_buf_clr = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        npu_rst_n = 1'b0;
        b8.npu_circ_buf_clr = 1'b0;
        b8.npu_circ_buf_circ_mode = 1'b0;
        b8.npu_circ_buf_write_en = 1'b0;
        b8.npu_circ_buf_read_en = 1'b0;
        b8.npu_circ_buf_data_input = '0;
        b5.npu_circ_buf_clr = 1'b0;
        b5.npu_circ_buf_circ_mode = 1'b0;
        b5.npu_circ_buf_write_en = 1'b0;
        b5.npu_circ_buf_read_en = 1'b0;
        b5.npu_circ_buf_data_input = '0;
        step();
        step();

        // Reset values
        chk("rst_valid", b8.npu_circ_buf_data_valid, 0);
        chk("rst_dout",  b8.npu_circ_buf_data_output, 0);
        chk("rst_count", b8.npu_circ_buf_count, 0);
        chk("rst_empty", b8.npu_circ_buf_empty, 1);
        chk("rst_full",  b8.npu_circ_buf_full, 0);
        chk("rst_err",   b8.npu_circ_buf_err, 0);
        chk("rst_pass",  b8.npu_circ_buf_pass_done, 0);
        npu_rst_n = 1'b1;
        repeat (3) step();
        chk("rel_empty", b8.npu_circ_buf_empty, 1);

        // Circular: 5 words, 12 reads
        b8.npu_circ_buf_circ_mode = 1'b1;
        for (int i = 0; i < 5; i++) wr8(16'(i + 1));
        chk("circ_count_load", b8.npu_circ_buf_count, 5);
        b8.npu_circ_buf_read_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("circ_dout",  b8.npu_circ_buf_data_output, (i % 5) + 1);
            chk("circ_valid", b8.npu_circ_buf_data_valid, 1);
            chk("circ_pass",  b8.npu_circ_buf_pass_done, (i == 4 || i == 9) ? 1 : 0);
            chk("circ_count", b8.npu_circ_buf_count, 5);
        end
        b8.npu_circ_buf_read_en = 1'b0;
        step();
        chk("idle_valid", b8.npu_circ_buf_data_valid, 0);
        chk("idle_hold",  b8.npu_circ_buf_data_output, 2);
        clr8();
        chk("clr1_count", b8.npu_circ_buf_count, 0);
        chk("clr1_empty", b8.npu_circ_buf_empty, 1);

        // Consume: fill, overflow, drain, underflow
        b8.npu_circ_buf_circ_mode = 1'b0;
        for (int i = 0; i < 8; i++) wr8(16'(16'hA0 + i));
        chk("cons_full",  b8.npu_circ_buf_full, 1);
        chk("cons_count", b8.npu_circ_buf_count, 8);
        wr8(16'h00FF);
        chk("ovf_err",   b8.npu_circ_buf_err, 3'b001);
        chk("ovf_count", b8.npu_circ_buf_count, 8);
        b8.npu_circ_buf_read_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("cons_dout",  b8.npu_circ_buf_data_output, 16'hA0 + i);
            chk("cons_valid", b8.npu_circ_buf_data_valid, 1);
            chk("cons_pass",  b8.npu_circ_buf_pass_done, 0);
            chk("cons_cnt",   b8.npu_circ_buf_count, 7 - i);
        end
        chk("drain_empty", b8.npu_circ_buf_empty, 1);
        step();
        chk("udf_valid", b8.npu_circ_buf_data_valid, 0);
        chk("udf_err",   b8.npu_circ_buf_err, 3'b011);
        b8.npu_circ_buf_read_en = 1'b0;
        clr8();

        // Write/read conflict at count=3
        wr8(16'h0011);
        wr8(16'h0022);
        wr8(16'h0033);
        chk("conf_pre_count", b8.npu_circ_buf_count, 3);
        b8.npu_circ_buf_read_en = 1'b1;
        wr8(16'h0044);
        b8.npu_circ_buf_read_en = 1'b0;
        chk("conf_count", b8.npu_circ_buf_count, 4);
        chk("conf_valid", b8.npu_circ_buf_data_valid, 0);
        chk("conf_err",   b8.npu_circ_buf_err, 3'b100);
        clr8();
        chk("clr2_count", b8.npu_circ_buf_count, 0);
        chk("clr2_empty", b8.npu_circ_buf_empty, 1);
        chk("clr2_err",   b8.npu_circ_buf_err, 0);

        // Mode toggle after 2 of 4 circular reads
        b8.npu_circ_buf_circ_mode = 1'b1;
        for (int i = 0; i < 4; i++) wr8(16'(16'hB0 + i));
        b8.npu_circ_buf_read_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("tog_circ_dout",  b8.npu_circ_buf_data_output, 16'hB0 + i);
            chk("tog_circ_count", b8.npu_circ_buf_count, 4);
        end
        b8.npu_circ_buf_circ_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("tog_cons_dout",  b8.npu_circ_buf_data_output, 16'hB0 + ((i + 2) % 4));
            chk("tog_cons_count", b8.npu_circ_buf_count, 3 - i);
            chk("tog_cons_pass",  b8.npu_circ_buf_pass_done, 0);
        end
        b8.npu_circ_buf_read_en = 1'b0;
        chk("tog_empty", b8.npu_circ_buf_empty, 1);
        clr8();

        // Reset during back-to-back reads
        b8.npu_circ_buf_circ_mode = 1'b1;
        wr8(16'h00C1);
        wr8(16'h00C2);
        wr8(16'h00C3);
        b8.npu_circ_buf_read_en = 1'b1;
        step();
        step();
        chk("mid_valid", b8.npu_circ_buf_data_valid, 1);
        chk("mid_dout",  b8.npu_circ_buf_data_output, 16'h00C2);
        npu_rst_n = 1'b0;
        #1;
        chk("arst_valid", b8.npu_circ_buf_data_valid, 0);
        chk("arst_dout",  b8.npu_circ_buf_data_output, 0);
        chk("arst_count", b8.npu_circ_buf_count, 0);
        chk("arst_empty", b8.npu_circ_buf_empty, 1);
        chk("arst_pass",  b8.npu_circ_buf_pass_done, 0);
        b8.npu_circ_buf_read_en = 1'b0;
        step();
        npu_rst_n = 1'b1;
        repeat (3) step();
        chk("post_empty", b8.npu_circ_buf_empty, 1);
        b8.npu_circ_buf_read_en = 1'b1;
        step();
        b8.npu_circ_buf_read_en = 1'b0;
        chk("post_udf_err",   b8.npu_circ_buf_err, 3'b010);
        chk("post_udf_valid", b8.npu_circ_buf_data_valid, 0);

        // DEPTH=5 wrap
        b5.npu_circ_buf_circ_mode = 1'b1;
        b5.npu_circ_buf_write_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b5.npu_circ_buf_data_input = 16'(16'h51 + i);
            step();
        end
        b5.npu_circ_buf_write_en = 1'b0;
        chk("d5_full",  b5.npu_circ_buf_full, 1);
        chk("d5_count", b5.npu_circ_buf_count, 5);
        b5.npu_circ_buf_read_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            chk("d5_dout",  b5.npu_circ_buf_data_output, 16'h51 + (i % 5));
            chk("d5_valid", b5.npu_circ_buf_data_valid, 1);
            chk("d5_pass",  b5.npu_circ_buf_pass_done, (i == 4 || i == 9) ? 1 : 0);
            chk("d5_cnt",   b5.npu_circ_buf_count, 5);
        end
        b5.npu_circ_buf_read_en = 1'b0;
        chk("d5_err", b5.npu_circ_buf_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/npu_circ_buf_param.md
Name: npu_circ_buf_param

Overview:
- Parametrised successor to the fixed 512x16 NPU weight/schedule circular buffer.
- Self-contained storage with its own register array; no vendor FIFO core.
- Selectable mode: circular (read word re-enqueued at tail) or consume (plain FIFO).
- Adds occupancy, full/empty, output-valid, end-of-pass pulse and sticky violation flags, so NPU sequencers can detect misuse instead of silently corrupting configuration.

Parameters:
- DATA_W, 16, word width in bits.
- DEPTH, 512, number of entries; any value >= 2, power of two not required.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- CLK  in  1  global 100 MHz clock.
- npu_rst_n  in  1  asynchronous active-low reset.
- npu_circ_buf_clr  in  1  synchronous clear (NPU config change); active high.
- npu_circ_buf_circ_mode  in  1  1 = circular, 0 = consume; sampled every cycle.
- npu_circ_buf_write_en  in  1  load strobe from config interface.
- npu_circ_buf_read_en  in  1  read strobe.
- npu_circ_buf_data_input  in  DATA_W  load data.
- npu_circ_buf_data_output  out  DATA_W  registered read data.
- npu_circ_buf_data_valid  out  1  data_output holds a fresh word this cycle.
- npu_circ_buf_pass_done  out  1  pulse: current valid word is the last of a pass.
- npu_circ_buf_count  out  ADDR_W+1  occupancy.
- npu_circ_buf_full  out  1  count == DEPTH.
- npu_circ_buf_empty  out  1  count == 0.
- npu_circ_buf_err  out  3  sticky flags: [0] overflow, [1] underflow, [2] read/write conflict.

Behaviour:
- Reset (async assert, sync release): pointers, count, pass index, data_output, data_valid, pass_done and err all 0; empty=1, full=0. Memory contents are not reset.
- Priority order: clr > write > read.
- clr: next cycle same state as reset, except memory is untouched. A simultaneous write or read is ignored and sets no error.
- Write with !full: mem[wr_ptr] <= din, wr_ptr advances, count +1.
- Write with full: dropped, err[0] set.
- Write and read in the same cycle: write performed, read ignored, err[2] set.
- Read with !empty: data_output <= mem[rd_ptr] and data_valid=1 on the next cycle (latency 1). rd_ptr advances.
  - Circular mode: same cycle, mem[wr_ptr] <= mem[rd_ptr], wr_ptr advances, count unchanged.
  - Consume mode: count -1.
- Read with empty: no state change, data_valid=0 next cycle, err[1] set.
- data_valid is a single-cycle qualifier. data_output holds its last value when no read occurs.
- Pointer wrap: pointer == DEPTH-1 advances to 0. Must be correct for non-power-of-two DEPTH.
- Pass tracking (circular mode only):
  - pass_idx counts successful reads.
  - On the read where pass_idx == count-1: pass_done asserts together with that word's data_valid, and pass_idx returns to 0.
  - A write or a mode change resets pass_idx to 0.
  - Consume mode: pass_done is always 0.
- err bits stay set until clr or reset.
- full/empty/count are registered and reflect state after the last clock edge.
- Reset asserted mid-read: data_valid drops immediately (async).

Test Plan:
- DEPTH=8, DATA_W=16: load 0x0001..0x0005, circ_mode=1, read 12 times -> outputs 1,2,3,4,5,1,2,3,4,5,1,2, each 1 cycle after its read; pass_done on the 5th and 10th valid words; count stays 5.
- Consume mode: load 0xA0..0xA7 -> full=1, count=8. 9th write -> err[0]=1, count stays 8. 8 reads -> A0..A7 then empty=1. 9th read -> err[1]=1, data_valid=0.
- DEPTH=5 (non-power-of-two): 5 loads, 13 circular reads -> sequence wraps correctly, no repeat or skip across the rd_ptr/wr_ptr 4->0 transition.
- Write and read asserted together with count=3 -> word written, count=4, no data_valid, err=3'b100. Then clr -> count=0, empty=1, err=0.
- Assert npu_rst_n low mid-stream of back-to-back reads -> all outputs 0 immediately. After release, empty=1, and a read sets err[1].
- Toggle circ_mode 1->0 after 2 of 4 circular reads -> pass_idx cleared; subsequent reads consume and count decrements 4,3,2,1,0.
